// File: rtl/transfer_sequencer_pkg.sv
// Shared types and constants for the SDRAM-to-SRAM frame transfer sequencer.
package transfer_sequencer_pkg;

   localparam int ADDR_W = 26;
   localparam int DIM_W  = 13;

   localparam logic [2:0] MODE_ROWMAJOR  = 3'd0;
   localparam logic [2:0] MODE_TRANSPOSE = 3'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_ADVANCE,
      ST_DONE
   } state_t;

   function automatic logic start_ok(input logic [DIM_W-1:0] w,
                                     input logic [DIM_W-1:0] h,
                                     input logic [2:0]       m);
      return (w != '0) && (h != '0) && ((m == MODE_ROWMAJOR) || (m == MODE_TRANSPOSE));
   endfunction

endpackage

// File: rtl/transfer_sequencer_pixel_counter.sv
// Row/column position within the frame; steps column-first and wraps into the next row.
module pixel_counter
   import transfer_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             step,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last_col,
   output logic             last_pixel
);

   logic [DIM_W-1:0] row_q, row_d;
   logic [DIM_W-1:0] col_q, col_d;

   assign last_col   = (col_q == width - DIM_W'(1));
   assign last_pixel = last_col && (row_q == height - DIM_W'(1));
   assign row        = row_q;
   assign col        = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (last_col) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
         end else begin
            col_d = col_q + DIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/transfer_sequencer.sv
// Frame transfer sequencer: reads each pixel from SDRAM (row-major) and writes it
// to SRAM, either as a straight copy or transposed.
//
// state      | meaning
// IDLE       | waiting for a start; rejected starts pulse error
// READ       | SDRAM read request held until sdram_ack
// WRITE      | SRAM write request held until sram_ack
// ADVANCE    | step position and both addresses
// DONE       | one-cycle done pulse
module transfer_sequencer
   import transfer_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [12:0]       width,
   input  logic [12:0]       height,
   input  logic [25:0]       start_address_sdram,
   input  logic [2:0]        mode,
   input  logic              sdram_ack,
   input  logic              sram_ack,
   output logic [25:0]       sdram_address,
   output logic [25:0]       sram_address,
   output logic              sdram_read,
   output logic              sram_write,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t state_q, state_d;

   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [2:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic              error_q, error_d;

   logic              start_accept;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col_unused;
   logic              last_col;
   logic              last_pixel;

   assign start_accept = (state_q == ST_IDLE) && start && start_ok(width, height, mode);

   pixel_counter u_pixel_counter (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (start_accept),
      .step       (state_q == ST_ADVANCE),
      .width      (width_q),
      .height     (height_q),
      .row        (row),
      .col        (col_unused),
      .last_col   (last_col),
      .last_pixel (last_pixel)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_accept) state_d = ST_READ;
         ST_READ:    if (sdram_ack)    state_d = ST_WRITE;
         ST_WRITE:   if (sram_ack)     state_d = ST_ADVANCE;
         ST_ADVANCE: state_d = last_pixel ? ST_DONE : ST_READ;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sdram_read = 1'b0;
      sram_write = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         ST_READ: begin
            sdram_read = 1'b1;
            busy       = 1'b1;
         end
         ST_WRITE: begin
            sram_write = 1'b1;
            busy       = 1'b1;
         end
         ST_ADVANCE: busy = 1'b1;
         ST_DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign sdram_address = sdram_addr_q;
   assign sram_address  = sram_addr_q;
   assign error         = error_q;

   // Transposed column steps add height; at a row wrap the next address is simply row+1.
   always_comb begin
      width_d      = width_q;
      height_d     = height_q;
      mode_d       = mode_q;
      sdram_addr_d = sdram_addr_q;
      sram_addr_d  = sram_addr_q;
      error_d      = 1'b0;
      if ((state_q == ST_IDLE) && start) begin
         if (start_accept) begin
            width_d      = width;
            height_d     = height;
            mode_d       = mode;
            sdram_addr_d = start_address_sdram;
            sram_addr_d  = '0;
         end else begin
            error_d = 1'b1;
         end
      end else if (state_q == ST_ADVANCE) begin
         sdram_addr_d = sdram_addr_q + ADDR_W'(1);
         if (mode_q == MODE_TRANSPOSE) begin
            sram_addr_d = last_col ? ADDR_W'(row) + ADDR_W'(1)
                                   : sram_addr_q + ADDR_W'(height_q);
         end else begin
            sram_addr_d = sram_addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         width_q      <= '0;
         height_q     <= '0;
         mode_q       <= '0;
         sdram_addr_q <= '0;
         sram_addr_q  <= '0;
         error_q      <= 1'b0;
      end else begin
         width_q      <= width_d;
         height_q     <= height_d;
         mode_q       <= mode_d;
         sdram_addr_q <= sdram_addr_d;
         sram_addr_q  <= sram_addr_d;
         error_q      <= error_d;
      end
   end

endmodule

// File: doc/transfer_sequencer.md
TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame transfer
- width  in  13  frame width in pixels
- height  in  13  frame height in pixels
- start_address_sdram  in  26  SDRAM address of pixel (0,0)
- mode  in  3  layout: 3'd0 row-major copy, 3'd1 transpose; others illegal
- sdram_ack  in  1  SDRAM read data valid for the current request
- sram_ack  in  1  SRAM write accepted
- sdram_address  out  26  current SDRAM read address
- sram_address  out  26  current SRAM write address
- sdram_read  out  1  SDRAM read request, level
- sram_write  out  1  SRAM write request, level
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on frame completion
- error  out  1  one-cycle pulse on rejected start

Function
REQ-002 SHALL latch width, height, start_address_sdram and mode on an accepted start; later input changes SHALL have no effect until the next start.
REQ-003 SHALL implement states IDLE, READ, WRITE, ADVANCE, DONE.
REQ-004 IDLE: start=1 with width!=0, height!=0 and mode in {0,1} -> READ; otherwise, with start=1 -> error pulse next cycle, remain IDLE.
REQ-005 READ: sdram_read=1; hold until sdram_ack=1 -> WRITE.
REQ-006 WRITE: sram_write=1; hold until sram_ack=1 -> ADVANCE.
REQ-007 ADVANCE: step col; at col=width-1, reset col to 0 and step row; if last pixel (row=height-1, col=width-1) -> DONE, else -> READ.
REQ-008 DONE: done=1 for exactly one cycle -> IDLE.
REQ-009 SDRAM traversal SHALL be row-major: sdram_address = start_address_sdram + row*width + col, modulo 2^26.
REQ-010 SRAM address, mode 0: row*width + col. Mode 1: col*height + row. Both modulo 2^26.
REQ-011 Addresses SHALL be maintained incrementally (add width/height/1 per step); no multipliers.
REQ-012 Addresses SHALL be stable and valid for the whole time sdram_read or sram_write is asserted.
REQ-013 sdram_read and sram_write SHALL never be asserted in the same cycle.
REQ-014 busy SHALL be 1 in READ, WRITE and ADVANCE; 0 in IDLE and DONE.
REQ-015 start while busy SHALL be ignored, with no error pulse.
REQ-016 An ack arriving outside its matching state SHALL be ignored.
REQ-017 Per-pixel latency SHALL be 3 cycles when both acks are returned combinationally.

Reset
REQ-018 n_rst=0 SHALL asynchronously force IDLE and clear every output, counter and latched register to 0.
REQ-019 Reset mid-transfer SHALL abandon the frame with no done pulse.
REQ-020 After reset release, the first accepted start SHALL behave identically to a cold start.

Structure
REQ-021 A shared package SHALL hold the state enum, the mode constants (MODE_ROWMAJOR=3'd0, MODE_TRANSPOSE=3'd1) and the address-width constant (26).
REQ-022 Row/column counting SHALL be one sub-module, pixel_counter, which provides row, col, last_col and last_pixel outputs.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Mode 0: width=4, height=2, start_address_sdram=0x100, immediate acks -> SDRAM addresses 0x100..0x107, SRAM addresses 0..7, done 24 cycles after start, exactly one done pulse.
- Mode 1: width=3, height=2 -> SRAM write address sequence 0,2,4,1,3,5.
- Zero size or illegal mode: start with width=0, or with mode=3'd5 -> one error pulse, busy stays 0, no requests issued.
- Backpressure: sdram_ack delayed 5 cycles and sram_ack delayed 2 cycles -> requests and addresses held stable throughout, no pixel skipped.
- Address wrap: start_address_sdram=0x3FFFFFE, width=4, height=1 -> SDRAM addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1.
- Reset mid-frame: n_rst pulsed low during WRITE -> all outputs 0 immediately, no done pulse; a new start then completes normally.
